w0rm_peripheral_memory_multiport: RTL and testbench

W0RM_PERIPHERAL_MEMORY_MULTIPORT -- requirements
Module: w0rm_peripheral_memory_multiport

---
 rtl/w0rm_peripheral_memory_multiport.sv | 85 ++++++++
 tb/tb_w0rm_peripheral_memory_multiport.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_peripheral_memory_multiport.sv
// w0rm_peripheral_memory_multiport: round-robin arbitrated single-port word memory shared by NUM_CH request channels
// Ports:
//   mem_clk, cpu_reset (async, active-low)
//   per channel i (slice i of each vector):
//     mem_valid_i/mem_read_i/mem_write_i, mem_addr_i, mem_data_i, mem_be_i, mem_user_i  request
//     mem_ready_o  combinational one-hot grant
//     mem_valid_o, mem_data_o, mem_user_o, mem_err_o  registered response, one cycle after acceptance
module w0rm_peripheral_memory_multiport #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          MEM_DEPTH  = 512,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          USER_WIDTH = 32,
  parameter int          NUM_CH     = 2
) (
  input  logic                             mem_clk,
  input  logic                             cpu_reset,
  input  logic [NUM_CH-1:0]                mem_valid_i,
  input  logic [NUM_CH-1:0]                mem_read_i,
  input  logic [NUM_CH-1:0]                mem_write_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     mem_data_i,
  input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] mem_be_i,
  input  logic [NUM_CH*USER_WIDTH-1:0]     mem_user_i,
  output logic [NUM_CH-1:0]                mem_ready_o,
  output logic [NUM_CH-1:0]                mem_valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]     mem_data_o,
  output logic [NUM_CH*USER_WIDTH-1:0]     mem_user_o,
  output logic [NUM_CH-1:0]                mem_err_o
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LB        = $clog2(BYTES);
  localparam int WORD_BITS = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int CH_W      = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [CH_W-1:0]       ptr, sel;
  logic                  acc, rd, wr, in_range, wr_en;
  logic [ADDR_WIDTH-1:0] addr, offset;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [BYTES-1:0]      be;
  logic [USER_WIDTH-1:0] user;
  logic [WORD_BITS-1:0]  widx;
  // Lowest valid channel at or above ptr wins, else lowest valid below ptr.
  always_comb begin
    sel = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (mem_valid_i[c] && c < int'(ptr)) sel = CH_W'(c);
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (mem_valid_i[c] && c >= int'(ptr)) sel = CH_W'(c);
  end
  assign acc         = cpu_reset && |mem_valid_i;
  assign mem_ready_o = acc ? NUM_CH'(1) << sel : '0;
  assign rd          = mem_read_i[sel];
  assign wr          = mem_write_i[sel];
  assign addr        = mem_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata       = mem_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign be          = mem_be_i[sel*BYTES +: BYTES];
  assign user        = mem_user_i[sel*USER_WIDTH +: USER_WIDTH];
  assign offset      = addr - ADDR_WIDTH'(BASE_ADDR);
  assign in_range    = addr >= ADDR_WIDTH'(BASE_ADDR) && (offset >> LB) < ADDR_WIDTH'(MEM_DEPTH);
  assign widx        = WORD_BITS'(offset >> LB);
  assign rdata       = mem[widx];
  assign wr_en       = acc && in_range && wr;
  always_ff @(posedge mem_clk)
    if (wr_en)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
  always_ff @(posedge mem_clk or negedge cpu_reset) begin
    if (!cpu_reset) begin
      ptr         <= '0;
      mem_valid_o <= '0;
      mem_data_o  <= '0;
      mem_user_o  <= '0;
      mem_err_o   <= '0;
    end else begin
      mem_valid_o <= mem_ready_o;
      if (acc) begin
        ptr                                    <= sel == CH_W'(NUM_CH - 1) ? '0 : sel + 1'b1;
        mem_data_o[sel*DATA_WIDTH +: DATA_WIDTH] <= in_range && rd ? rdata : '0;
        mem_user_o[sel*USER_WIDTH +: USER_WIDTH] <= user;
        mem_err_o[sel]                         <= (rd || wr) && !in_range;
      end
    end
  end
endmodule

// File: tb/tb_w0rm_peripheral_memory_multiport.sv
// tb_w0rm_peripheral_memory_multiport: scoreboard bench for the multiport memory
module tb_w0rm_peripheral_memory_multiport;
  localparam int NC = 2;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic             mem_clk = 0;
  logic             cpu_reset = 0;
  logic [NC-1:0]    mem_valid_i = '0, mem_read_i = '0, mem_write_i = '0;
  logic [NC*32-1:0] mem_addr_i = '0, mem_data_i = '0, mem_user_i = '0;
  logic [NC*4-1:0]  mem_be_i = '0;
  logic [NC-1:0]    mem_ready_o, mem_valid_o, mem_err_o;
  logic [NC*32-1:0] mem_data_o, mem_user_o;
  typedef struct {int ch; logic [31:0] data; logic [31:0] user; logic err;} rsp_t;
  rsp_t exp_q[$];
  logic [31:0] model [int];
  int ptr = 0;
  int checks = 0, errors = 0;

  w0rm_peripheral_memory_multiport dut (
    .mem_clk(mem_clk), .cpu_reset(cpu_reset),
    .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_be_i(mem_be_i), .mem_user_i(mem_user_i),
    .mem_ready_o(mem_ready_o), .mem_valid_o(mem_valid_o), .mem_data_o(mem_data_o),
    .mem_user_o(mem_user_o), .mem_err_o(mem_err_o)
  );

  always #5 mem_clk = ~mem_clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int ch, input bit v, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic [31:0] u);
    mem_valid_i[ch] = v;
    mem_read_i[ch] = rd;
    mem_write_i[ch] = wr;
    mem_addr_i[ch*32 +: 32] = a;
    mem_data_i[ch*32 +: 32] = d;
    mem_be_i[ch*4 +: 4] = be;
    mem_user_i[ch*32 +: 32] = u;
  endtask

  // One clock: check grant against the round-robin model, push expected response, check after the edge.
  task automatic cycle(output logic [NC-1:0] g);
    logic [NC-1:0] eg;
    logic [31:0] a, old;
    bit inr;
    int w;
    rsp_t e;
    #1;
    eg = '0;
    for (int j = 0; j < NC; j++) begin
      int c = (ptr + j) % NC;
      if (eg == 0 && mem_valid_i[c]) eg[c] = 1'b1;
    end
    g = eg;
    checks++;
    if (mem_ready_o !== eg) begin
      errors++;
      $display("FAIL grant ready=%b expected=%b", mem_ready_o, eg);
    end
    for (int c = 0; c < NC; c++) if (eg[c]) begin
      a = mem_addr_i[c*32 +: 32];
      w = int'((a - BASE) >> 2);
      inr = a >= BASE && ((a - BASE) >> 2) < 512;
      old = (inr && model.exists(w)) ? model[w] : 32'h0;
      e.ch = c;
      e.user = mem_user_i[c*32 +: 32];
      e.err = (mem_read_i[c] || mem_write_i[c]) && !inr;
      e.data = (inr && mem_read_i[c]) ? old : 32'h0;
      exp_q.push_back(e);
      if (inr && mem_write_i[c])
        for (int b = 0; b < 4; b++) if (mem_be_i[c*4+b]) old[b*8 +: 8] = mem_data_i[c*32 + b*8 +: 8];
      if (inr && mem_write_i[c]) model[w] = old;
      ptr = (c + 1) % NC;
    end
    @(posedge mem_clk);
    #1;
    checks++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (mem_valid_o !== NC'(1 << e.ch) || mem_data_o[e.ch*32 +: 32] !== e.data ||
          mem_user_o[e.ch*32 +: 32] !== e.user || mem_err_o[e.ch] !== e.err) begin
        errors++;
        $display("FAIL response ch%0d valid=%b data=%h user=%h err=%b expected data=%h user=%h err=%b",
                 e.ch, mem_valid_o, mem_data_o[e.ch*32 +: 32], mem_user_o[e.ch*32 +: 32], mem_err_o[e.ch],
                 e.data, e.user, e.err);
      end
    end else if (mem_valid_o !== '0) begin
      errors++;
      $display("FAIL idle_valid valid=%b expected=0", mem_valid_o);
    end
  endtask

  task automatic req(input int ch, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input logic [31:0] u);
    logic [NC-1:0] g;
    bit done = 0;
    set_req(ch, 1, rd, wr, a, d, be, u);
    for (int k = 0; k < 10 && !done; k++) begin
      cycle(g);
      done = g[ch];
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout ch%0d addr=%h", ch, a);
    end
    mem_valid_i[ch] = 1'b0;
  endtask

  task automatic check_word(input string name, input int ch, input logic [31:0] exp_d, input logic exp_e);
    checks++;
    if (mem_data_o[ch*32 +: 32] !== exp_d || mem_err_o[ch] !== exp_e) begin
      errors++;
      $display("FAIL %s data=%h err=%b expected data=%h err=%b", name, mem_data_o[ch*32 +: 32], mem_err_o[ch], exp_d, exp_e);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (mem_ready_o !== '0 || mem_valid_o !== '0 || mem_data_o !== '0 || mem_user_o !== '0 || mem_err_o !== '0) begin
      errors++;
      $display("FAIL %s ready=%b valid=%b data=%h user=%h err=%b expected all 0",
               name, mem_ready_o, mem_valid_o, mem_data_o, mem_user_o, mem_err_o);
    end
  endtask

  task automatic release_reset();
    @(posedge mem_clk);
    #1;
    cpu_reset = 1'b1;
    ptr = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    set_req(0, 1, 1, 0, BASE, 0, 4'hF, 32'h1);
    set_req(1, 1, 1, 0, BASE, 0, 4'hF, 32'h2);
    repeat (2) @(posedge mem_clk);
    #2;
    check_zero_outputs("reset_state");
    mem_valid_i = '0;
    release_reset();
  endtask

  task automatic test_write_read();
    req(0, 0, 1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 32'h11);
    check_word("write_resp", 0, 32'h0, 1'b0);
    req(0, 1, 0, 32'h4000_0010, 32'h0, 4'h0, 32'h12);
    check_word("read_full", 0, 32'hDEAD_BEEF, 1'b0);
    req(0, 0, 1, 32'h4000_0010, 32'h0000_00AA, 4'b0001, 32'h13);
    req(0, 1, 0, 32'h4000_0013, 32'h0, 4'h0, 32'h14);
    check_word("read_partial", 0, 32'hDEAD_BEAA, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] g;
    logic [31:0] tag [NC];
    req(1, 0, 1, 32'h4000_0014, 32'h5555_1234, 4'hF, 32'h20);
    cpu_reset = 1'b0;
    release_reset();
    tag[0] = 32'h100;
    tag[1] = 32'h200;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 1, 0, 32'h4000_0010, 0, 4'h0, tag[0]);
      set_req(1, 1, 1, 0, 32'h4000_0014, 0, 4'h0, tag[1]);
      cycle(g);
      checks++;
      if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rr_order cycle%0d grant=%b expected=%b", i, g, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      for (int c = 0; c < NC; c++) if (g[c]) tag[c]++;
    end
    mem_valid_i = '0;
    cycle(g);
  endtask

  task automatic test_out_of_range();
    req(0, 0, 1, 32'h4000_0000, 32'h1111_1111, 4'hF, 32'h30);
    req(0, 1, 0, 32'h4000_0800, 32'h0, 4'h0, 32'h31);
    check_word("oor_high", 0, 32'h0, 1'b1);
    req(1, 1, 0, 32'h3FFF_FFFC, 32'h0, 4'h0, 32'h32);
    check_word("oor_low", 1, 32'h0, 1'b1);
    req(1, 0, 1, 32'h4000_0800, 32'hBAD0_BAD0, 4'hF, 32'h33);
    check_word("oor_write", 1, 32'h0, 1'b1);
    req(0, 0, 1, 32'h4000_07FF, 32'hCAFE_F00D, 4'hF, 32'h34);
    req(0, 1, 0, 32'h4000_07FC, 32'h0, 4'h0, 32'h35);
    check_word("last_word", 0, 32'hCAFE_F00D, 1'b0);
    req(1, 1, 0, 32'h4000_0000, 32'h0, 4'h0, 32'h36);
    check_word("word0_intact", 1, 32'h1111_1111, 1'b0);
  endtask

  task automatic test_rmw();
    req(0, 1, 1, 32'h4000_0000, 32'h2222_2222, 4'hF, 32'h40);
    check_word("rmw_old", 0, 32'h1111_1111, 1'b0);
    req(0, 1, 0, 32'h4000_0000, 32'h0, 4'h0, 32'h41);
    check_word("rmw_new", 0, 32'h2222_2222, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int k = 0; k < 8; k++) begin
      a = 32'h4000_0100 + 32'(k * 4);
      req(1, 0, 1, a, $urandom, 4'hF, 32'h500 + 32'(k));
      req(1, 0, 1, a, $urandom, 4'($urandom_range(0, 15)), 32'h600 + 32'(k));
      req(1, 1, 0, a, 32'h0, 4'h0, 32'h700 + 32'(k));
    end
    req(0, 0, 0, 32'h4000_0100, 32'hFFFF_FFFF, 4'hF, 32'h800);
    check_word("no_op", 0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_drop();
    req(0, 1, 0, 32'h4000_0010, 32'h0, 4'h0, 32'h900);
    set_req(0, 1, 1, 0, 32'h4000_0000, 0, 4'h0, 32'h901);
    #1;
    checks++;
    if (mem_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_ready ready=%b expected=01", mem_ready_o);
    end
    cpu_reset = 1'b0;
    #1;
    check_zero_outputs("reset_async");
    @(posedge mem_clk);
    #1;
    check_zero_outputs("reset_dropped");
    mem_valid_i = '0;
    release_reset();
    req(0, 1, 0, 32'h4000_0000, 32'h0, 4'h0, 32'h902);
    check_word("retain_w0", 0, 32'h2222_2222, 1'b0);
    req(1, 1, 0, 32'h4000_0010, 32'h0, 4'h0, 32'h903);
    check_word("retain_w4", 1, 32'hDEAD_BEAA, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_rmw();
    test_back_to_back();
    test_reset_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
